// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 8-digit hex scan reader:
//     - digit index type (3 bits, digit 0 = least significant nibble)
//     - 16-entry hex segment pattern table, active-high, bit order {g,f,e,d,c,b,a}
//     - all-off segment pattern
//     - helper function mapping a nibble to its segment pattern
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIBBLE_W   = 4;
    localparam int SEG_W      = 7;
    localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

    typedef logic [2:0]       digit_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam digit_t FIRST_DIGIT = 3'd0;
    localparam digit_t LAST_DIGIT  = 3'd7;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Hex glyphs 0..F, active-high {g,f,e,d,c,b,a}. Lower-case b and d keep
    // them distinguishable from 8 and 0.
    localparam seg_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
//   Purely combinational 4-bit hex to 7-segment decoder (active-high).
//   Ports:
//     i_nibble  in  4  hex digit value
//     o_seg     out 7  segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output seg_t                o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = hex_to_seg(4'h0);
            4'h1: o_seg = hex_to_seg(4'h1);
            4'h2: o_seg = hex_to_seg(4'h2);
            4'h3: o_seg = hex_to_seg(4'h3);
            4'h4: o_seg = hex_to_seg(4'h4);
            4'h5: o_seg = hex_to_seg(4'h5);
            4'h6: o_seg = hex_to_seg(4'h6);
            4'h7: o_seg = hex_to_seg(4'h7);
            4'h8: o_seg = hex_to_seg(4'h8);
            4'h9: o_seg = hex_to_seg(4'h9);
            4'hA: o_seg = hex_to_seg(4'hA);
            4'hB: o_seg = hex_to_seg(4'hB);
            4'hC: o_seg = hex_to_seg(4'hC);
            4'hD: o_seg = hex_to_seg(4'hD);
            4'hE: o_seg = hex_to_seg(4'hE);
            4'hF: o_seg = hex_to_seg(4'hF);
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//   Captures a 32-bit word on a load strobe and scans it as 8 hex digits onto
//   a multiplexed 7-segment display. Loads go into a shadow register and are
//   promoted to the visible register only at a frame boundary, so a single
//   scan frame never mixes two words.
//
//   Parameters:
//     SCAN_DIV    clk cycles per digit slot (>= 2)
//     DIGITS      number of digits, must stay 8 (one nibble each)
//     ACTIVE_LOW  1 = an/seg/dp active-low, 0 = active-high
//
//   Ports:
//     clk          in   1  system clock
//     clr_n        in   1  asynchronous active-low reset
//     datain       in  32  word to display
//     en           in   1  load strobe, datain sampled on this posedge
//     blank_lz     in   1  1 = blank leading-zero digits (live, not frame-aligned)
//     dp_mask      in   8  decimal point enable, bit i = digit i
//     an           out  8  digit anode select, bit i = digit i
//     seg          out  7  segments {g,f,e,d,c,b,a}
//     dp           out  1  decimal point
//     frame_start  out  1  one-cycle pulse when digit 0 becomes active
//     pending      out  1  a loaded word waits for the next frame boundary
// ---------------------------------------------------------------------------
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DIGITS     = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [WORD_W-1:0]  datain,
    input  logic               en,
    input  logic               blank_lz,
    input  logic [DIGITS-1:0]  dp_mask,
    output logic [DIGITS-1:0]  an,
    output seg_t               seg,
    output logic               dp,
    output logic               frame_start,
    output logic               pending
);

    localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // Output inversion mask: applied only at the output registers so all
    // internal logic stays active-high.
    localparam logic              POL      = (ACTIVE_LOW != 0);

    // ---------------- state ----------------
    logic [DIV_W-1:0]   r_div_cnt;
    digit_t             r_digit;
    logic [WORD_W-1:0]  r_shadow;
    logic [WORD_W-1:0]  r_visible;
    logic               r_pending;
    logic               r_frame_start;
    logic [DIGITS-1:0]  r_an;
    seg_t               r_seg;
    logic               r_dp;

    // ---------------- combinational ----------------
    logic                             w_wrap;
    logic                             w_boundary;
    logic                             w_promote;
    logic                             w_pending_next;
    logic [DIGITS-1:0][NIBBLE_W-1:0]  w_nibbles;
    logic [DIGITS-1:0]                w_lz_blank;
    logic [DIGITS-1:0]                w_an_act;
    logic [NIBBLE_W-1:0]              w_nibble;
    seg_t                             w_seg_raw;

    assign w_wrap     = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_wrap && (r_digit == LAST_DIGIT);
    assign w_promote  = w_boundary && r_pending;

    // A load on the boundary edge itself lands in shadow after the old shadow
    // has moved to visible, so it must stay pending for the following frame.
    assign w_pending_next = en || (r_pending && !w_boundary);

    // Per-digit nibble extraction, leading-zero detection and anode select.
    // A digit counts as a leading zero when it and every digit above it are
    // zero; digit 0 is never blanked so a zero word still shows "0".
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_nibbles[gi] = r_visible[NIBBLE_W*gi +: NIBBLE_W];

            if (gi == 0) begin : g_lsd
                assign w_lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_lz_blank[gi] = (r_visible[WORD_W-1:NIBBLE_W*gi] == '0);
            end

            assign w_an_act[gi] = (r_digit == digit_t'(gi)) &&
                                  !(blank_lz && w_lz_blank[gi]);
        end
    endgenerate

    assign w_nibble = w_nibbles[r_digit];

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_raw)
    );

    // ---------------- divider and digit scan ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_div_cnt     <= '0;
            r_digit       <= FIRST_DIGIT;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_digit   <= (r_digit == LAST_DIGIT) ? FIRST_DIGIT : r_digit + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // ---------------- double buffer ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_shadow  <= '0;
            r_visible <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_promote) begin
                r_visible <= r_shadow;
            end
            if (en) begin
                r_shadow <= datain;
            end
            r_pending <= w_pending_next;
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_an  <= {DIGITS{POL}};
            r_seg <= {SEG_W{POL}};
            r_dp  <= POL;
        end else begin
            r_an  <= w_an_act ^ {DIGITS{POL}};
            r_seg <= w_seg_raw ^ {SEG_W{POL}};
            r_dp  <= dp_mask[r_digit] ^ POL;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//   Directed plus randomized stimulus for seg7_scan_reader (SCAN_DIV=4,
//   ACTIVE_LOW=1). Expected outputs come from a cycle-count model: after n
//   clock edges since reset release the scan position is (n/4)%8, a frame
//   boundary is every 32nd edge, and the displayed word follows the
//   shadow/visible promotion rule.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] datain = '0;
    logic        en = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic        pending;

    always #5 clk = ~clk;

    seg7_scan_reader #(
        .SCAN_DIV   (SD),
        .DIGITS     (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .datain      (datain),
        .en          (en),
        .blank_lz    (blank_lz),
        .dp_mask     (dp_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start),
        .pending     (pending)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_edges  = 0;
    logic [31:0] m_vis    = '0;
    logic [31:0] m_shadow = '0;
    logic        m_pend   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h, expected %0h", tag, n_edges, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, {24'h0, an}, 32'hFF);
        chk({tag, "_seg"}, {25'h0, seg}, 32'h7F);
        chk({tag, "_dp"}, {31'h0, dp}, 32'h1);
        chk({tag, "_fs"}, {31'h0, frame_start}, 32'h0);
        chk({tag, "_pending"}, {31'h0, pending}, 32'h0);
    endtask

    // One clock edge: update the model with the inputs present at the edge,
    // then check every output at the following falling edge.
    task automatic tick();
        int         d;
        logic       bnd;
        logic [7:0] act;
        logic [3:0] nib;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        d   = (n_edges / SD) % 8;
        bnd = ((n_edges + 1) % FRAME) == 0;
        nib = 4'((m_vis >> (4 * d)) & 32'hF);
        act = 8'(1 << d);
        if (blank_lz && d != 0 && (m_vis >> (4 * d)) == 32'h0) act = 8'h00;
        e_an  = ~act;
        e_seg = ~HEX[nib];
        e_dp  = ~dp_mask[d];
        if (bnd && m_pend) begin
            m_vis  = m_shadow;
            m_pend = 1'b0;
        end
        if (en) begin
            m_shadow = datain;
            m_pend   = 1'b1;
        end
        n_edges++;
        @(negedge clk);
        chk("an", {24'h0, an}, {24'h0, e_an});
        chk("seg", {25'h0, seg}, {25'h0, e_seg});
        chk("dp", {31'h0, dp}, {31'h0, e_dp});
        chk("frame_start", {31'h0, frame_start}, {31'h0, bnd});
        chk("pending", {31'h0, pending}, {31'h0, m_pend});
    endtask

    task automatic load(input logic [31:0] value);
        datain = value;
        en     = 1'b1;
        tick();
        en     = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        clr_n = 1'b1;

        // Idle scan: every digit shows "0", frame_start every 32 edges
        repeat (40) tick();

        // Mid-frame load of 12345678
        while (n_edges % FRAME != 13) tick();
        load(32'h12345678);
        repeat (2 * FRAME) tick();

        // Two loads in one frame: only the last one is ever shown
        dp_mask = 8'h81;
        while (n_edges % FRAME != 3) tick();
        load(32'hAAAA0000);
        repeat (6) tick();
        load(32'hDEADBEEF);
        repeat (2 * FRAME) tick();

        // Load coincident with the frame boundary edge
        dp_mask = 8'h00;
        while (n_edges % FRAME != 5) tick();
        load(32'h11111111);
        while ((n_edges + 1) % FRAME != 0) tick();
        load(32'h22222222);
        repeat (2 * FRAME) tick();

        // Leading-zero blanking
        blank_lz = 1'b1;
        load(32'h000000A5);
        repeat (3 * FRAME) tick();
        load(32'h00000000);
        repeat (3 * FRAME) tick();
        blank_lz = 1'b0;

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            datain = $urandom >> ($urandom_range(0, 8) * 4);
            en     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
            tick();
        end
        en       = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 8'h00;

        // Reset held for 3 cycles during digit 5 with 12345678 visible
        load(32'h12345678);
        while (m_pend) tick();
        while (!(((n_edges / SD) % 8) == 5 && (n_edges % SD) == 1)) tick();
        clr_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("midreset_hold");
        end
        n_edges  = 0;
        m_vis    = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        clr_n    = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
